led_pattern_ctrl: RTL and testbench

Parametrised multi-channel LED pattern controller. It replaces the single hard-wired blink counter with one shared tick prescaler and CHANNELS independent channels. Each channel is configured at run time as off, on, periodic blink or one-shot pulse. It sits between board-level control logic and the LEDR pins, clocked directly from the 50 MHz board clock.

---
 rtl/led_pattern_ctrl.sv | 123 ++++++++++++
 tb/tb_led_pattern_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Multi-channel LED pattern controller. One shared tick
//                prescaler drives CHANNELS independent channels, each set at
//                run time to OFF, ON, periodic BLINK or one-shot PULSE.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                cfg_we,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  cfg_ch,
   input  logic [1:0]                                          cfg_mode,
   input  logic [CNT_W-1:0]                                    cfg_period,
   output logic [CHANNELS-1:0]                                 led,
   output logic [CHANNELS-1:0]                                 busy
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int DIV  = CLK_FREQ / TICK_HZ;
   localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PC_W-1:0]  C_PC_LAST = PC_W'(DIV - 1);
   localparam logic [PC_W-1:0]  C_PC_ONE  = PC_W'(1);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W:0]   C_ONE_X   = (CNT_W + 1)'(1);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PULSE = 2'b11
   } mode_t;

   logic [PC_W-1:0] r_pc;
   logic            w_tick;

   // Tick is the single cycle where the prescaler sits at its last count.
   assign w_tick = (r_pc == C_PC_LAST);

   // Free-running prescaler; only reset ever clears it, never a config write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (w_tick) begin
         r_pc <= '0;
      end else begin
         r_pc <= r_pc + C_PC_ONE;
      end
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         mode_t            r_mode;
         logic [CNT_W-1:0] r_period;
         logic [CNT_W-1:0] r_cnt;
         logic             r_led;
         logic             r_busy;
         logic             w_sel;
         logic [CNT_W-1:0] w_per_eff;
         logic             w_last;

         // Index values beyond CHANNELS-1 match no channel and are dropped.
         assign w_sel     = cfg_we && (cfg_ch == CH_W'(gi));
         // A stored period of zero behaves as one tick.
         assign w_per_eff = (r_period == '0) ? C_ONE : r_period;
         // Extended by one bit so cnt+1 cannot wrap before the compare.
         assign w_last    = (({1'b0, r_cnt} + C_ONE_X) == {1'b0, w_per_eff});

         // Channel state: a write wins over a coincident tick.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_mode   <= MODE_OFF;
               r_period <= '0;
               r_cnt    <= '0;
               r_led    <= 1'b0;
               r_busy   <= 1'b0;
            end else if (w_sel) begin
               r_mode   <= mode_t'(cfg_mode);
               r_period <= cfg_period;
               r_cnt    <= '0;
               r_led    <= (cfg_mode != MODE_OFF);
               r_busy   <= (cfg_mode == MODE_PULSE);
            end else if (w_tick) begin
               case (r_mode)
                  MODE_BLINK: begin
                     if (w_last) begin
                        r_led <= ~r_led;
                        r_cnt <= '0;
                     end else begin
                        r_cnt <= r_cnt + C_ONE;
                     end
                  end
                  MODE_PULSE: begin
                     if (w_last) begin
                        r_led  <= 1'b0;
                        r_busy <= 1'b0;
                        r_mode <= MODE_OFF;
                        r_cnt  <= '0;
                     end else begin
                        r_cnt <= r_cnt + C_ONE;
                     end
                  end
                  default: begin
                     r_cnt <= r_cnt;
                  end
               endcase
            end
         end

         assign led[gi]  = r_led;
         assign busy[gi] = r_busy;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Self-checking bench for led_pattern_ctrl with a reference
//                model built from tick counts since each channel write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

   localparam int DIV = 10;
   localparam int NCH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_period;
   logic [3:0] led;
   logic [3:0] busy;

   logic       cfg_we5;
   logic [2:0] cfg_ch5;
   logic [1:0] cfg_mode5;
   logic [7:0] cfg_period5;
   logic [4:0] led5;
   logic [4:0] busy5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   led_pattern_ctrl #(
      .CLK_FREQ(100), .TICK_HZ(10), .CHANNELS(4), .CNT_W(8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode), .cfg_period(cfg_period), .led(led), .busy(busy)
   );

   led_pattern_ctrl #(
      .CLK_FREQ(100), .TICK_HZ(10), .CHANNELS(5), .CNT_W(8)
   ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5),
      .cfg_mode(cfg_mode5), .cfg_period(cfg_period5), .led(led5), .busy(busy5)
   );

   // Reference model: cycle count for the tick, and per channel the mode,
   // effective period and number of ticks seen since the last write.
   int m_pc;
   bit m_tick;
   int m_mode  [NCH];
   int m_per   [NCH];
   int m_ticks [NCH];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 0;
         for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 0; m_per[i] = 1; m_ticks[i] = 0;
         end
      end else begin
         m_tick = (m_pc == DIV - 1);
         m_pc   = (m_pc + 1) % DIV;
         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && (int'(cfg_ch) == i)) begin
               m_mode[i]  = int'(cfg_mode);
               m_per[i]   = (cfg_period == 0) ? 1 : int'(cfg_period);
               m_ticks[i] = 0;
            end else if (m_tick) begin
               m_ticks[i]++;
            end
         end
      end
   end

   function automatic logic [3:0] exp_led();
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) begin
         case (m_mode[i])
            1:       v[i] = 1'b1;
            2:       v[i] = ((m_ticks[i] / m_per[i]) % 2) == 0;
            3:       v[i] = m_ticks[i] < m_per[i];
            default: v[i] = 1'b0;
         endcase
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_busy();
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i] = (m_mode[i] == 3) && (m_ticks[i] < m_per[i]);
      return v;
   endfunction

   // Drive one write cycle; called at a falling edge, returns at the next one.
   task automatic do_write(input int ch, input int mode, input int per);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_period = 8'(per);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic do_write5(input int ch, input int mode, input int per);
      cfg_we5 = 1'b1; cfg_ch5 = 3'(ch); cfg_mode5 = 2'(mode); cfg_period5 = 8'(per);
      @(negedge clk);
      cfg_we5 = 1'b0;
   endtask

   task automatic test_reset();
      int first_fall, first_rise;
      logic prev;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 4'b0000 || busy !== 4'b0000) begin
         errors++; $display("FAIL reset_async led=%b busy=%b want 0000/0000", led, busy);
      end
      checks++;
      if (led5 !== 5'b0 || busy5 !== 5'b0) begin
         errors++; $display("FAIL reset_async5 led=%b busy=%b want 0", led5, busy5);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (led !== 4'b0000 || busy !== 4'b0000) begin
         errors++; $display("FAIL reset_hold led=%b busy=%b want 0000/0000", led, busy);
      end
      rst_n = 1'b1;
      do_write(0, 2, 1);
      checks++;
      if (led !== 4'b0001) begin
         errors++; $display("FAIL reset_first_write led=%b want 0001", led);
      end
      first_fall = -1; first_rise = -1; prev = led[0];
      for (int n = 2; n <= 25; n++) begin
         @(negedge clk);
         if (prev && !led[0] && first_fall < 0) first_fall = n;
         if (!prev && led[0] && first_rise < 0) first_rise = n;
         prev = led[0];
         checks++;
         if (led !== exp_led()) begin
            errors++; $display("FAIL prescale_model n=%0d led=%b want %b", n, led, exp_led());
         end
      end
      checks++;
      if (first_fall != 10 || first_rise != 20) begin
         errors++; $display("FAIL tick_spacing fall=%0d rise=%0d want 10/20", first_fall, first_rise);
      end
   endtask

   task automatic test_blink();
      int chg[3];
      int nchg;
      logic prev;
      do_write(0, 2, 3);
      checks++;
      if (led !== 4'b0001) begin
         errors++; $display("FAIL blink_start led=%b want 0001", led);
      end
      nchg = 0; prev = led[0];
      for (int n = 1; n <= 150; n++) begin
         @(negedge clk);
         if (led[0] != prev && nchg < 3) begin chg[nchg] = n; nchg++; end
         prev = led[0];
         checks++;
         if (led !== exp_led() || busy !== 4'b0000) begin
            errors++; $display("FAIL blink_model n=%0d led=%b busy=%b want %b/0000", n, led, busy, exp_led());
         end
      end
      checks++;
      if (nchg != 3 || chg[0] < 21 || chg[0] > 30 || chg[1] - chg[0] != 30 || chg[2] - chg[0] != 60) begin
         errors++; $display("FAIL blink_period toggles=%0d first=%0d spacing=%0d,%0d want 3,21..30,30,60",
                            nchg, chg[0], chg[1] - chg[0], chg[2] - chg[0]);
      end
   endtask

   task automatic test_pulse();
      int fall;
      do_write(1, 3, 2);
      checks++;
      if (led[1] !== 1'b1 || busy !== 4'b0010) begin
         errors++; $display("FAIL pulse_start led1=%b busy=%b want 1/0010", led[1], busy);
      end
      fall = -1;
      for (int n = 1; n <= 75; n++) begin
         @(negedge clk);
         if (!busy[1] && fall < 0) fall = n;
         checks++;
         if (led !== exp_led() || busy !== exp_busy()) begin
            errors++; $display("FAIL pulse_model n=%0d led=%b busy=%b want %b/%b", n, led, busy, exp_led(), exp_busy());
         end
      end
      checks++;
      if (fall < 11 || fall > 20 || led[1] !== 1'b0) begin
         errors++; $display("FAIL pulse_end fall=%0d led1=%b want 11..20/0", fall, led[1]);
      end
      do_write(1, 3, 2);
      repeat (10) @(negedge clk);
      do_write(1, 3, 2);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         checks++;
         if (busy[1] !== 1'b1) begin
            errors++; $display("FAIL pulse_restart n=%0d busy1=%b want 1", n, busy[1]);
         end
      end
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         checks++;
         if (led !== exp_led() || busy !== exp_busy()) begin
            errors++; $display("FAIL pulse_tail n=%0d led=%b busy=%b want %b/%b", n, led, busy, exp_led(), exp_busy());
         end
      end
   endtask

   task automatic test_collision();
      for (int k = 0; k < DIV && m_pc != DIV - 1; k++) @(negedge clk);
      checks++;
      if (m_pc != DIV - 1) begin
         errors++; $display("FAIL collide_align pc=%0d want %0d", m_pc, DIV - 1);
      end
      do_write(2, 2, 1);
      checks++;
      if (led[2] !== 1'b1 || led !== exp_led()) begin
         errors++; $display("FAIL collide_write led=%b want %b with bit2=1", led, exp_led());
      end
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         checks++;
         if (led[2] !== (n < 10) || led !== exp_led()) begin
            errors++; $display("FAIL collide_next n=%0d led=%b want %b", n, led, exp_led());
         end
      end
   endtask

   task automatic test_boundary();
      int toggles;
      logic prev;
      do_write(3, 2, 0);
      toggles = 0; prev = led[3];
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (led[3] != prev) toggles++;
         prev = led[3];
         checks++;
         if (led !== exp_led()) begin
            errors++; $display("FAIL period0_model n=%0d led=%b want %b", n, led, exp_led());
         end
      end
      checks++;
      if (toggles != 3) begin
         errors++; $display("FAIL period0_toggles got=%0d want 3", toggles);
      end
      do_write(3, 1, 5);
      checks++;
      if (led[3] !== 1'b1) begin
         errors++; $display("FAIL on_write led3=%b want 1", led[3]);
      end
      do_write(3, 0, 5);
      checks++;
      if (led[3] !== 1'b0 || busy[3] !== 1'b0) begin
         errors++; $display("FAIL off_write led3=%b busy3=%b want 0/0", led[3], busy[3]);
      end
   endtask

   task automatic test_out_of_range();
      for (int ch = 5; ch <= 7; ch++) begin
         do_write5(ch, 1 + (ch % 3), 2);
         checks++;
         if (led5 !== 5'b00000 || busy5 !== 5'b00000) begin
            errors++; $display("FAIL oor_ch%0d led=%b busy=%b want 0/0", ch, led5, busy5);
         end
      end
      do_write5(4, 1, 0);
      checks++;
      if (led5 !== 5'b10000 || busy5 !== 5'b00000) begin
         errors++; $display("FAIL ch4_on led=%b busy=%b want 10000/00000", led5, busy5);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            cfg_we     = 1'b1;
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(0, 4));
         end
         @(negedge clk);
         cfg_we = 1'b0;
         checks++;
         if (led !== exp_led() || busy !== exp_busy()) begin
            errors++; $display("FAIL random_model n=%0d led=%b busy=%b want %b/%b", n, led, busy, exp_led(), exp_busy());
         end
      end
   endtask

   task automatic test_reset_mid();
      do_write(0, 2, 2);
      do_write(1, 3, 5);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 4'b0000 || busy !== 4'b0000 || led5 !== 5'b0) begin
         errors++; $display("FAIL reset_mid led=%b busy=%b led5=%b want 0", led, busy, led5);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         checks++;
         if (led !== 4'b0000 || busy !== 4'b0000) begin
            errors++; $display("FAIL post_reset n=%0d led=%b busy=%b want 0000/0000", n, led, busy);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0;
      cfg_we5 = 1'b0; cfg_ch5 = '0; cfg_mode5 = '0; cfg_period5 = '0;
      test_reset();
      test_blink();
      test_pulse();
      test_collision();
      test_boundary();
      test_out_of_range();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
